rs_syndrome_engine: RTL

//   Parametrised Reed-Solomon syndrome engine over GF(2^M); first stage of the RS decode pipeline, feeding the key-equation solver.

---
 rtl/rs_pkg.sv | 35 +++
 rtl/rs_horner_cell.sv | 28 ++
 rtl/rs_syndrome_engine.sv | 112 +++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared types and GF(2^m) helpers for the Reed-Solomon decode pipeline.
// The helpers are written for elaboration-time and constant-operand use, for fields up to GF(2^16).
package rs_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int GF_W      = 16;
  localparam int M_DEFAULT = 3;

  typedef logic [M_DEFAULT-1:0] sym_t;
  typedef logic [GF_W-1:0]      gf_t;

  // Carry-less product followed by reduction modulo prim_poly (which includes the x^m term).
  function automatic gf_t gf_mul(input gf_t a, input gf_t b, input int m, input gf_t prim_poly);
    logic [2*GF_W-1:0] prod;
    prod = '0;
    for (int i = 0; i < GF_W; i++) begin
      if (i < m && b[i]) prod = prod ^ ({{GF_W{1'b0}}, a} << i);
    end
    for (int k = 2*GF_W-2; k >= 0; k--) begin
      if (k >= m && prod[k]) prod = prod ^ ({{GF_W{1'b0}}, prim_poly} << (k - m));
    end
    return prod[GF_W-1:0];
  endfunction

  function automatic gf_t gf_alpha_pow(input int k, input int m, input gf_t prim_poly);
    int  e;
    gf_t r;
    e = k % ((1 << m) - 1);
    r = gf_t'(1);
    for (int i = 0; i < e; i++) r = gf_mul(r, gf_t'(2), m, prim_poly);
    return r;
  endfunction

endpackage

// File: rtl/rs_horner_cell.sv
// One Horner accumulator: acc <= acc * MULT ^ sym per enabled cycle, MULT a constant root of the code.
module rs_horner_cell
  import rs_pkg::*;
#(
  parameter int           M         = 3,
  parameter logic [M-1:0] MULT      = 1,
  parameter int           PRIM_POLY = 'hB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [M-1:0] sym,
  output logic [M-1:0] acc
);

  logic [M-1:0] acc_scaled;

  assign acc_scaled = M'(gf_mul(gf_t'(acc), gf_t'(MULT), M, gf_t'(PRIM_POLY)));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_scaled ^ sym;
  end

endmodule

// File: rtl/rs_syndrome_engine.sv
// Reed-Solomon syndrome engine: NSYN parallel Horner evaluations, one symbol per cycle, valid/ready on both sides.
// Optional build macro RS_SYND_ZERO_FLAG_EN adds the registered syn_zero output.
module rs_syndrome_engine
  import rs_pkg::*;
#(
  parameter int M         = 3,
  parameter int N         = 7,
  parameter int NSYN      = 4,
  parameter int FCR       = 1,
  parameter int PRIM_POLY = 'hB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*M-1:0]    in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NSYN*M-1:0] out_syn
`ifdef RS_SYND_ZERO_FLAG_EN
  ,
  output logic              syn_zero
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         state, state_next;
  logic [CW-1:0]  count;
  logic [N*M-1:0] cw_q;
  logic [M-1:0]   sym_cur;
  logic           accept;
  logic           calc_en;
  logic           last_sym;

  assign accept   = in_valid && in_ready;
  assign calc_en  = (state == CALC);
  assign last_sym = calc_en && (count == '0);
  assign sym_cur  = cw_q[int'(count)*M +: M];

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (count == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (accept)                     count <= CW'(N - 1);
      else if (calc_en && count != 0) count <= count - 1'b1;
    end
  end

  // NOTE: the shadow codeword is pure datapath, only read after a fresh load, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) cw_q <= in_cw;
  end

  logic [NSYN-1:0] next_zero;

  for (genvar j = 0; j < NSYN; j++) begin : g_syn
    localparam logic [M-1:0] ROOT = M'(gf_alpha_pow(FCR + j, M, gf_t'(PRIM_POLY)));

    rs_horner_cell #(
      .M         (M),
      .MULT      (ROOT),
      .PRIM_POLY (PRIM_POLY)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .en    (calc_en),
      .sym   (sym_cur),
      .acc   (out_syn[j*M +: M])
    );

    // The final Horner step yields zero exactly when the scaled accumulator equals the last symbol.
    assign next_zero[j] =
      (M'(gf_mul(gf_t'(out_syn[j*M +: M]), gf_t'(ROOT), M, gf_t'(PRIM_POLY))) == sym_cur);
  end

`ifdef RS_SYND_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (!reset)                         syn_zero <= 1'b0;
    else if (last_sym)                  syn_zero <= &next_zero;
    else if (out_valid && out_ready)    syn_zero <= 1'b0;
  end
`else
  logic unused_zero;
  assign unused_zero = &{1'b0, next_zero, last_sym};
`endif

endmodule
